// File: rtl/serial_add_sub.sv
// Digit-serial adder/subtractor: DIGIT bits per clock through a ripple chain,
// with valid/ready handshakes on operands and result.
module serial_add_sub #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("serial_add_sub: illegal WIDTH/DIGIT combination");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [WIDTH-1:0]  a_sh_r, b_sh_r, res_r, res_nxt_s;
  logic [WIDTH-1:0]  sum_r;
  logic              carry_r, cout_r, ovf_r;
  logic              in_ready_r, out_valid_r;
  logic [CW-1:0]     cnt_r;
  logic [DIGIT-1:0]  dsum_s;
  logic [DIGIT:0]    c_s;
  logic              load_s, step_s, done_s, last_s;

  assign last_s = (cnt_r == CW'(NDIG - 1));

  // Ripple chain over the low digit; c_s[i] is the carry into bit i of the digit.
  always_comb begin
    logic c_v;
    c_v    = carry_r;
    c_s    = {(DIGIT + 1){1'b0}};
    c_s[0] = carry_r;
    dsum_s = {DIGIT{1'b0}};
    for (int i = 0; i < DIGIT; i++) begin
      dsum_s[i] = a_sh_r[i] ^ b_sh_r[i] ^ c_v;
      c_v       = (a_sh_r[i] & b_sh_r[i]) | (c_v & (a_sh_r[i] ^ b_sh_r[i]));
      c_s[i+1]  = c_v;
    end
    res_nxt_s = (res_r >> DIGIT) | (WIDTH'(dsum_s) << (WIDTH - DIGIT));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    step_s      = 1'b0;
    done_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          load_s      = 1'b1;
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        step_s = 1'b1;
        if (last_s) begin
          done_s      = 1'b1;
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Handshake flags follow the next state so they are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      in_ready_r  <= (state_nxt_s == IDLE);
      out_valid_r <= (state_nxt_s == DONE);
    end
  end

  // Operand shifters, running carry, digit counter and result accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_r  <= {WIDTH{1'b0}};
      b_sh_r  <= {WIDTH{1'b0}};
      res_r   <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      cnt_r   <= {CW{1'b0}};
    end else if (load_s) begin
      a_sh_r  <= a;
      b_sh_r  <= sub ? ~b : b;
      carry_r <= sub ? 1'b1 : cin;
      cnt_r   <= {CW{1'b0}};
    end else if (step_s) begin
      a_sh_r  <= a_sh_r >> DIGIT;
      b_sh_r  <= b_sh_r >> DIGIT;
      res_r   <= res_nxt_s;
      carry_r <= c_s[DIGIT];
      cnt_r   <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Visible result only changes on the final digit; the last digit's carries give ovf.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_r  <= {WIDTH{1'b0}};
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else if (done_s) begin
      sum_r  <= res_nxt_s;
      cout_r <= c_s[DIGIT];
      ovf_r  <= c_s[DIGIT-1] ^ c_s[DIGIT];
    end else begin
      sum_r <= sum_r;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign sum       = sum_r;
  assign cout      = cout_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_serial_add_sub.sv
// Bench for serial_add_sub: five instances (8/2, 8/1, 4/1, 4/2, 4/4) checked
// every cycle against an arithmetic reference, plus literal pinned results.
module tb_serial_add_sub;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       in_valid[5], in_ready[5], out_valid[5], out_ready[5];
  logic       cin[5], sub[5], cout[5], ovf[5];
  logic [7:0] a[5], b[5], sum_v[5];
  logic [7:0] s0, s1;
  logic [3:0] s2, s3, s4;

  int wk[5] = '{8, 8, 4, 4, 4};
  int lk[5] = '{4, 8, 4, 2, 1};

  serial_add_sub #(.WIDTH(8), .DIGIT(2)) u0 (.clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .a(a[0]), .b(b[0]), .cin(cin[0]), .sub(sub[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .sum(s0), .cout(cout[0]), .ovf(ovf[0]));
  serial_add_sub #(.WIDTH(8), .DIGIT(1)) u1 (.clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .a(a[1]), .b(b[1]), .cin(cin[1]), .sub(sub[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .sum(s1), .cout(cout[1]), .ovf(ovf[1]));
  serial_add_sub #(.WIDTH(4), .DIGIT(1)) u2 (.clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .a(a[2][3:0]), .b(b[2][3:0]), .cin(cin[2]), .sub(sub[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .sum(s2), .cout(cout[2]), .ovf(ovf[2]));
  serial_add_sub #(.WIDTH(4), .DIGIT(2)) u3 (.clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[3]), .in_ready(in_ready[3]), .a(a[3][3:0]), .b(b[3][3:0]), .cin(cin[3]), .sub(sub[3]),
    .out_valid(out_valid[3]), .out_ready(out_ready[3]), .sum(s3), .cout(cout[3]), .ovf(ovf[3]));
  serial_add_sub #(.WIDTH(4), .DIGIT(4)) u4 (.clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[4]), .in_ready(in_ready[4]), .a(a[4][3:0]), .b(b[4][3:0]), .cin(cin[4]), .sub(sub[4]),
    .out_valid(out_valid[4]), .out_ready(out_ready[4]), .sum(s4), .cout(cout[4]), .ovf(ovf[4]));

  always_comb begin
    sum_v[0] = s0;
    sum_v[1] = s1;
    sum_v[2] = {4'h0, s2};
    sum_v[3] = {4'h0, s3};
    sum_v[4] = {4'h0, s4};
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit tmo     = 1'b0;

  // Pinned literal expectation for one DUT's next result: {ovf, cout, sum}.
  bit         pin_on = 1'b0;
  int         pin_k  = 0;
  logic [9:0] pin_exp = 10'h000;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: {cout,sum} = a + (sub?~b:b) + (sub?1:cin); ovf from operand/result signs.
  function automatic logic [9:0] ref_op(int w, logic [7:0] x, logic [7:0] y, logic ci, logic s);
    logic [7:0] m, xx, yy, r;
    logic [8:0] t;
    logic       co, ov;
    m  = (w == 8) ? 8'hFF : 8'h0F;
    xx = x & m;
    yy = (s ? ~y : y) & m;
    t  = {1'b0, xx} + {1'b0, yy} + {8'h00, (s ? 1'b1 : ci)};
    if (w == 8) begin
      r  = t[7:0];
      co = t[8];
    end else begin
      r  = {4'h0, t[3:0]};
      co = t[4];
    end
    ov = (xx[w-1] == yy[w-1]) && (r[w-1] != xx[w-1]);
    return {ov, co, r};
  endfunction

  task automatic chk(string nm, int k, logic [9:0] act, logic [9:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d at cycle %0d: got %h, expected %h", nm, k, cyc, act, exp);
    end
  endtask

  // Model state per DUT.
  bit         busy[5];
  int         acc[5];
  logic [9:0] cur[5], last[5];

  // Single compare process: samples between edges and advances the model.
  always @(negedge clk or negedge rst_n) begin
    logic [9:0] act, er;
    logic [7:0] m;
    logic       ev;
    #1;
    chk("timeout", 0, {9'h000, tmo}, 10'h000);
    for (int k = 0; k < 5; k++) begin
      m   = (wk[k] == 8) ? 8'hFF : 8'h0F;
      act = {ovf[k], cout[k], sum_v[k] & m};
      if (!rst_n) begin
        chk("rst_in_ready", k, {9'h000, in_ready[k]}, 10'h001);
        chk("rst_out_valid", k, {9'h000, out_valid[k]}, 10'h000);
        chk("rst_result", k, act, 10'h000);
        busy[k] = 1'b0;
        last[k] = 10'h000;
        cur[k]  = 10'h000;
      end else begin
        ev = busy[k] && (cyc >= acc[k] + lk[k]);
        er = ev ? cur[k] : last[k];
        chk("in_ready", k, {9'h000, in_ready[k]}, {9'h000, !busy[k]});
        chk("out_valid", k, {9'h000, out_valid[k]}, {9'h000, ev});
        chk("result", k, act, er);
        if (pin_on && pin_k == k && ev) begin
          chk("pin_dut", k, act, pin_exp);
          chk("pin_model", k, cur[k], pin_exp);
        end
        if (!busy[k] && in_valid[k]) begin
          busy[k] = 1'b1;
          acc[k]  = cyc + 1;
          cur[k]  = ref_op(wk[k], a[k], b[k], cin[k], sub[k]);
        end else if (ev && out_ready[k]) begin
          busy[k] = 1'b0;
          last[k] = cur[k];
        end
      end
    end
  end

  // One transaction: idle gap, held in_valid until taken, then hold off out_ready.
  task automatic run(int k, logic [7:0] av, logic [7:0] bv, logic ci, logic s,
                     int igap, int ogap, bit poke);
    int   bud;
    logic rb;
    repeat (igap) begin @(posedge clk); #1; end
    a[k] = av; b[k] = bv; cin[k] = ci; sub[k] = s; in_valid[k] = 1'b1;
    bud = 0;
    do begin
      rb = in_ready[k];
      @(posedge clk); #1;
      bud++;
    end while (!rb && bud < 50);
    if (!rb) tmo = 1'b1;
    in_valid[k] = 1'b0;
    a[k] = 8'($urandom); b[k] = 8'($urandom); cin[k] = 1'($urandom); sub[k] = 1'($urandom);
    bud = 0;
    while (!out_valid[k] && bud < 50) begin @(posedge clk); #1; bud++; end
    if (!out_valid[k]) tmo = 1'b1;
    for (int i = 0; i < ogap; i++) begin
      if (poke) in_valid[k] = (i == 1);
      @(posedge clk); #1;
    end
    in_valid[k] = 1'b0;
    out_ready[k] = 1'b1;
    @(posedge clk); #1;
    out_ready[k] = 1'b0;
  endtask

  task automatic pinned(int k, logic [7:0] av, logic [7:0] bv, logic ci, logic s,
                        int ogap, bit poke, logic [9:0] exp);
    pin_k = k; pin_exp = exp; pin_on = 1'b1;
    run(k, av, bv, ci, s, 1, ogap, poke);
    pin_on = 1'b0;
  endtask

  initial begin
    logic [9:0] v;
    for (int k = 0; k < 5; k++) begin
      in_valid[k] = 1'b0; out_ready[k] = 1'b0; a[k] = 8'h00; b[k] = 8'h00;
      cin[k] = 1'b0; sub[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    pinned(0, 8'h5A, 8'h3C, 1'b1, 1'b0, 0, 1'b0, 10'h297);
    pinned(0, 8'h10, 8'h20, 1'b1, 1'b1, 1, 1'b0, 10'h0F0);
    pinned(0, 8'h80, 8'h01, 1'b0, 1'b1, 0, 1'b0, 10'h37F);
    pinned(1, 8'hFF, 8'h01, 1'b0, 1'b0, 0, 1'b0, 10'h100);
    pinned(0, 8'h7F, 8'h01, 1'b0, 1'b0, 5, 1'b1, 10'h280);

    // Asynchronous reset during the second RUN cycle, held across one falling edge.
    @(posedge clk); #1;
    a[0] = 8'h33; b[0] = 8'h11; in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    @(negedge clk); #2;
    rst_n = 1'b1;
    pinned(0, 8'h01, 8'h01, 1'b0, 1'b0, 0, 1'b0, 10'h002);

    for (int k = 2; k < 5; k++) begin
      for (int i = 0; i < 1024; i++) begin
        v = i[9:0];
        run(k, {4'h0, v[3:0]}, {4'h0, v[7:4]}, v[8], v[9],
            int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'b0);
      end
    end

    repeat (3) @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_add_sub.md
Name: serial_add_sub

Overview:
Parametrised digit-serial adder/subtractor. It accepts two WIDTH-bit operands through a valid/ready handshake and processes DIGIT bits per clock through a ripple full-adder chain. It presents sum, carry-out and signed overflow through a second valid/ready handshake. It replaces per-operand combinational full-adder arrays wherever area matters more than latency.

Parameters:
WIDTH, 16, operand and result width in bits; must be ≥ 2.
DIGIT, 4, bits processed per cycle; 1 ≤ DIGIT ≤ WIDTH; WIDTH % DIGIT == 0 (elaboration error otherwise).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands valid
in_ready  output  1  block can accept operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in; used only when sub=0
sub  input  1  0: a+b+cin; 1: a-b (two's complement)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result
cout  output  1  carry out of MSB; in sub mode, 1 means no borrow
ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State IDLE.
  - in_ready=1, out_valid=0, sum=0, cout=0, ovf=0.
  - Internal shift registers, carry and digit counter all cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&in_ready at a rising edge:
    - latch a into A_sh;
    - latch (sub ? ~b : b) into B_sh;
    - carry ← (sub ? 1 : cin);
    - count ← 0;
    - go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each cycle, add the low DIGIT bits of A_sh and B_sh with carry through a DIGIT-bit ripple chain.
  - Shift A_sh and B_sh right by DIGIT.
  - Shift the DIGIT result bits into the MSB end of a result register.
  - Update carry with the chain output; count++.
  - On the cycle count == WIDTH/DIGIT-1:
    - record the carry into bit WIDTH-1 (internal carry of the chain at the last bit) for ovf;
    - go to DONE.
- DONE:
  - out_valid=1; sum, cout and ovf are driven from registers.
  - While out_ready=0, sum, cout, ovf and out_valid hold stable indefinitely, and in_ready=0.
  - On out_valid&out_ready, go to IDLE; out_valid falls and in_ready rises on the next cycle.
- Latency:
  - out_valid rises exactly WIDTH/DIGIT cycles after the accepting edge.
  - With DIGIT=WIDTH, it rises 1 cycle after.
- Throughput: one operation per WIDTH/DIGIT+2 cycles minimum.
- Output registers after the output handshake:
  - sum, cout and ovf keep their last values after the handshake.
  - They are updated only on the RUN→DONE transition.
  - The output registers must not show partial results during RUN; the result accumulates in a separate register.
- Arithmetic:
  - Modulo 2^WIDTH; cout is bit WIDTH of the unsigned sum.
  - In sub mode, cin is ignored.
  - Operand and mode changes on the inputs during RUN/DONE are ignored.
- in_valid while not in IDLE: not accepted; the producer must hold it until it sees in_ready.
- Reset mid-RUN or mid-DONE: the operation is discarded with no output handshake; state and outputs return to reset values immediately.

Test Plan:
1. WIDTH=8, DIGIT=2, a=8'h5A, b=8'h3C, cin=1, sub=0 -> after 4 cycles: out_valid=1, sum=8'h97, cout=0, ovf=1.
2. WIDTH=8, DIGIT=2:
   - a=8'h10, b=8'h20, sub=1, cin=1 -> sum=8'hF0, cout=0, ovf=0 (cin ignored).
   - a=8'h80, b=8'h01, sub=1 -> sum=8'h7F, cout=1, ovf=1.
3. WIDTH=8, DIGIT=1, a=8'hFF, b=8'h01, cin=0 -> out_valid exactly 8 cycles after accept; sum=8'h00, cout=1, ovf=0.
4. Backpressure with out_ready=0 for 5 cycles after out_valid:
   - sum, cout and ovf stable; in_ready=0; a new in_valid pulse is not accepted.
   - Raise out_ready -> out_valid falls next cycle, then in_ready=1.
5. Reset mid-RUN: pulse rst_n low asynchronously (between edges) at cycle 2 of RUN -> in_ready=1, out_valid=0, sum=0 immediately. The next transaction, 8'h01+8'h01, gives sum=8'h02.
6. Exhaustive sweep, WIDTH=4 with DIGIT in {1,2,4}: all a, b, cin, sub combinations (1024 each) streamed with random in_valid/out_ready gaps -> every result matches the reference model {cout,sum} = a + (sub?~b:b) + (sub?1:cin), with ovf matching the signed rule.
